if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 33 +++
 rtl/if_stage.sv | 155 +++++++++++++++
 tb/tb_if_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, default reset PC, fetch FSM states and
// small PC helpers used by the instruction-fetch stage.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DROP,
    S_HOLD
  } if_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Sequential fetch; FFFF_FFFC + 4 wraps naturally to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry skid buffer holding an instruction that arrived while the
// pipeline was stalled.
module fetch_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk) begin
    if (rst || clear)
      valid <= 1'b0;
    else if (load)
      valid <= 1'b1;
    else if (drain)
      valid <= 1'b0;
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register, redirect/drop handling and a
// stall skid buffer. Define IF_PERF_CNT_EN to add fetch/bubble counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        fetch_busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  if_state_t   state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_pc, drop_pc_nxt;
  logic [31:0] redir_pc;
  logic        buf_load, buf_drain, buf_clear;
  logic        buf_vld;
  logic [31:0] buf_pc, buf_instr;
  logic        new_vld;
  logic [31:0] new_pc, new_instr;
  logic        ld_valid, ld_bubble;

  assign redir_pc   = align_pc(redirect_pc);
  assign imem_req   = (state != S_HOLD);
  // While dropping, the abandoned address must stay on the bus until its ack.
  assign imem_addr  = (state == S_DROP) ? drop_pc : pc;
  assign fetch_busy = imem_req && !imem_ack;

  fetch_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .drain    (buf_drain),
    .clear    (buf_clear),
    .pc_in    (pc),
    .instr_in (imem_rdata),
    .valid    (buf_vld),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    drop_pc_nxt = drop_pc;
    buf_load    = 1'b0;
    buf_drain   = 1'b0;
    buf_clear   = 1'b0;
    new_vld     = 1'b0;
    new_pc      = pc;
    new_instr   = imem_rdata;
    case (state)
      S_FETCH: begin
        if (redirect_en) begin
          pc_nxt = redir_pc;
          if (!imem_ack) begin
            drop_pc_nxt = pc;
            state_nxt   = S_DROP;
          end
        end else if (imem_ack) begin
          pc_nxt = next_pc(pc);
          if (stall) begin
            buf_load  = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            new_vld = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (redirect_en)
          pc_nxt = redir_pc;
        if (imem_ack)
          state_nxt = S_FETCH;
      end
      S_HOLD: begin
        if (redirect_en) begin
          buf_clear = 1'b1;
          pc_nxt    = redir_pc;
          state_nxt = S_FETCH;
        end else if (!stall) begin
          buf_drain = 1'b1;
          new_vld   = buf_vld;
          new_pc    = buf_pc;
          new_instr = buf_instr;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Flush beats stall beats new data; an unstalled cycle without data is a bubble.
  assign ld_bubble = flush || (!stall && !new_vld);
  assign ld_valid  = !flush && !stall && new_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    drop_pc <= drop_pc_nxt;
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (rst || ld_bubble) begin
      pc_out          <= 32'h0;
      instruction_out <= NOP_INSTR;
      valid_out       <= 1'b0;
    end else if (ld_valid) begin
      pc_out          <= new_pc;
      instruction_out <= new_instr;
      valid_out       <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (ld_valid)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (ld_bubble)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: kept fetches are queued when acked and
// popped when IF/ID is expected to load.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic        fetch_busy;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .fetch_busy      (fetch_busy)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .bubble_cnt      (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic [31:0] m_pc, m_ins;
  logic        m_vld;
  int          m_fetch, m_bubble;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_ifid();
    check("pc_out", pc_out, m_pc);
    check("instruction_out", instruction_out, m_ins);
    check("valid_out", 32'(valid_out), 32'(m_vld));
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0;
    redirect_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    m_pc = 32'h0; m_ins = 32'h0; m_vld = 1'b0;
    m_fetch = 0; m_bubble = 0;
    check_ifid();
    check("rst_imem_req", 32'(imem_req), 32'd1);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_fetch_busy", 32'(fetch_busy), 32'd1);
`ifdef IF_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_cnt, 32'h0);
    check("rst_bubble_cnt", bubble_cnt, 32'h0);
`endif
  endtask

  // One clock of stimulus; keep=1 means an acked word must eventually reach IF/ID.
  task automatic cyc(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                     input logic ak, input logic [31:0] data, input logic exp_req,
                     input logic [31:0] exp_addr, input logic keep);
    logic [63:0] e;
    stall = st; flush = fl; redirect_en = rd; redirect_pc = rpc;
    imem_ack = ak; imem_rdata = data;
    #1;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    check("fetch_busy", 32'(fetch_busy), 32'(exp_req & ~ak));
    if (rd) sb.delete();
    if (ak && keep) sb.push_back({exp_addr, data});
    @(posedge clk); #1;
    if (fl) begin
      if (!st && sb.size() > 0) e = sb.pop_front();
      m_pc = 32'h0; m_ins = 32'h0; m_vld = 1'b0; m_bubble++;
    end else if (!st) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        m_pc = e[63:32]; m_ins = e[31:0]; m_vld = 1'b1; m_fetch++;
      end else begin
        m_pc = 32'h0; m_ins = 32'h0; m_vld = 1'b0; m_bubble++;
      end
    end
    check_ifid();
  endtask

  initial begin
    do_reset();
    // Streaming, one instruction per cycle
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 0, 1, w(32'(4 * i)), 1, 32'(4 * i), 1);
    // Ack while stalled: buffered, request dropped until release
    cyc(1, 0, 0, 0, 1, 32'h2001_0005, 1, 32'h10, 1);
    for (int i = 0; i < 2; i++)
      cyc(1, 0, 0, 0, 0, 0, 0, 32'h14, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h14, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h14, 0);
    cyc(0, 0, 0, 0, 1, w(32'h14), 1, 32'h14, 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h18, 0);
    // Reset with the request at 0x18 still outstanding
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 0, 1, w(32'(4 * i)), 1, 32'(4 * i), 1);
    // Redirect while waiting for ack
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h10, 0);
    cyc(0, 0, 1, 32'h40, 0, 0, 1, 32'h10, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h10, 0);
    cyc(0, 0, 0, 0, 1, w(32'h10), 1, 32'h10, 0);
    cyc(0, 0, 0, 0, 1, w(32'h40), 1, 32'h40, 1);
    // Second redirect during drop only retargets pc
    cyc(0, 0, 1, 32'h200, 0, 0, 1, 32'h44, 0);
    cyc(0, 0, 1, 32'h302, 0, 0, 1, 32'h44, 0);
    cyc(0, 0, 0, 0, 1, w(32'h44), 1, 32'h44, 0);
    cyc(0, 0, 0, 0, 1, w(32'h300), 1, 32'h300, 1);
    // Redirect coincident with ack at 0x8, unaligned target
    do_reset();
    cyc(0, 0, 0, 0, 1, w(32'h0), 1, 32'h0, 1);
    cyc(0, 0, 0, 0, 1, w(32'h4), 1, 32'h4, 1);
    cyc(0, 0, 1, 32'h103, 1, w(32'h8), 1, 32'h8, 0);
    cyc(0, 0, 0, 0, 1, w(32'h100), 1, 32'h100, 1);
    // Flush with stall, then flush of an acked word
    cyc(1, 1, 0, 0, 0, 0, 1, 32'h104, 0);
    cyc(0, 1, 0, 0, 1, w(32'h104), 1, 32'h104, 1);
    cyc(0, 0, 0, 0, 1, w(32'h108), 1, 32'h108, 1);
    // Redirect while holding a buffered word
    cyc(1, 0, 0, 0, 1, w(32'h10C), 1, 32'h10C, 1);
    cyc(1, 0, 1, 32'h500, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 1, w(32'h500), 1, 32'h500, 1);
    // PC wrap-around
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1, w(32'h504), 1, 32'h504, 0);
    cyc(0, 0, 0, 0, 1, w(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 0, 1, w(32'h0), 1, 32'h0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h4, 0);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 32'(m_fetch));
    check("bubble_cnt", bubble_cnt, 32'(m_bubble));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
